serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor for the gate-level arithmetic library: computes DIFF = A − B − BIN one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the full-adder cell. It is intended for area-minimal datapaths and as a sequential stress case for the simulator, exercising feedback through a flip-flop, counters, an FSM and a start/done handshake.

---
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BIN, one bit per clock, LSB first,
// built around a single full-subtractor cell with a registered borrow and a start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  function automatic logic fs_diff(input logic a, input logic b, input logic br);
    fs_diff = a ^ b ^ br;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic br);
    fs_borrow = (~a & b) | (~(a ^ b) & br);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_sd_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  // Next-state decode plus the combinational full-subtractor cell on the current LSBs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_d         = fs_diff(r_sa[0], r_sb[0], r_br);
    w_br_nxt    = fs_borrow(r_sa[0], r_sb[0], r_br);
    w_sd_nxt    = {w_d, r_sd[WIDTH-1:1]};
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = DONE_S;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE_S: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, operand shifters, borrow, counter and held result; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sd    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE_S);
      if (w_accept) begin
        r_sa  <= i_a;
        r_sb  <= i_b;
        r_br  <= i_bin;
        r_cnt <= '0;
        r_sd  <= '0;
      end else if (r_state == RUN) begin
        r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
        r_br  <= w_br_nxt;
        r_sd  <= w_sd_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_sd_nxt;
          r_bout <= w_br_nxt;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_diff = r_diff;
  assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected {BOUT,DIFF}; a monitor pops on every DONE pulse.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n, start, bin;
  logic [7:0] a, b;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       rst4_n, start4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_done = -1;
  bit chk_period = 1'b0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b), .i_bin(bin),
    .o_busy(busy), .o_done(done), .o_diff(diff), .o_bout(bout)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_start(start4), .i_a(a4), .i_b(b4), .i_bin(bin4),
    .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_bout(bout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every DONE, off the active edge.
  initial begin
    logic [8:0] e8;
    logic [4:0] e4;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1 && done === 1'b1) begin
        tests++;
        if (q8.size() == 0) begin
          fails++;
          $display("FAIL dut8_unexpected_done: got DONE with diff=0x%0h bout=%0b, expected none", diff, bout);
        end else begin
          e8 = q8.pop_front();
          if ({bout, diff} !== e8) begin
            fails++;
            $display("FAIL dut8_result: got {bout,diff}=0x%0h expected 0x%0h", {bout, diff}, e8);
          end
        end
        if (chk_period) begin
          if (last_done >= 0) begin
            tests++;
            if (cyc - last_done != 9) begin
              fails++;
              $display("FAIL b2b_period: got %0d cycles expected 9", cyc - last_done);
            end
          end
          last_done = cyc;
        end else begin
          last_done = -1;
        end
      end
      if (rst4_n === 1'b1 && done4 === 1'b1) begin
        tests++;
        if (q4.size() == 0) begin
          fails++;
          $display("FAIL dut4_unexpected_done: got diff=0x%0h bout=%0b, expected none", diff4, bout4);
        end else begin
          e4 = q4.pop_front();
          if ({bout4, diff4} !== e4) begin
            fails++;
            $display("FAIL dut4_result: got {bout,diff}=0x%0h expected 0x%0h", {bout4, diff4}, e4);
          end
        end
      end
    end
  end

  // Wait (bounded) until the 8-bit unit is not busy, scrambling operands meanwhile.
  task automatic wait_ready8();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_ready8_timeout", 1, 0);
  endtask

  // Present one request at the current negedge; it is accepted on the next posedge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int n;
    logic [8:0] b2b_in [4];
    logic [8:0] b2b_a  [4];
    logic [8:0] b2b_ex [4];

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    rst4_n = 1'b0; start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst4_n = 1'b1;
    chk("reset_diff_bout", {bout, diff}, 9'h000);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset4_outputs", {busy4, done4, bout4, diff4}, 7'h00);

    // 0x5A - 0x23: latency and BUSY length
    q8.push_back({1'b0, 8'h37});
    start_op(8'h5A, 8'h23, 1'b0);
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    chk("t1_done_latency", lat, 9);
    chk("t1_busy_cycles", busy_cnt, 8);

    wait_ready8();
    q8.push_back({1'b1, 8'hFF});
    start_op(8'h00, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_result_held_midrun", {bout, diff}, 9'h037);

    wait_ready8();
    q8.push_back({1'b1, 8'hFF});
    start_op(8'h10, 8'h10, 1'b1);

    wait_ready8();
    q8.push_back({1'b0, 8'hFE});
    start_op(8'hFF, 8'h00, 1'b1);

    // START mid-RUN is ignored
    wait_ready8();
    q8.push_back({1'b0, 8'h7F});
    start_op(8'h80, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'h00; b = 8'hFF; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready8();
    repeat (12) @(negedge clk);
    chk("t5_single_done", q8.size(), 0);
    chk("t5_idle_after", {busy, done}, 2'b00);

    // START held high: back-to-back every 9 cycles
    b2b_in[0] = {1'b1, 8'h00}; b2b_a[0] = {1'b0, 8'hFF}; b2b_ex[0] = {1'b1, 8'h00};
    b2b_in[1] = {1'b1, 8'h01}; b2b_a[1] = {1'b0, 8'h02}; b2b_ex[1] = {1'b1, 8'hFE};
    b2b_in[2] = {1'b0, 8'h5A}; b2b_a[2] = {1'b0, 8'h23}; b2b_ex[2] = {1'b0, 8'h37};
    b2b_in[3] = {1'b1, 8'hC8}; b2b_a[3] = {1'b0, 8'h64}; b2b_ex[3] = {1'b0, 8'h63};
    chk_period = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready8();
      a = b2b_in[i][7:0]; b = b2b_a[i][7:0]; bin = b2b_in[i][8];
      q8.push_back(b2b_ex[i]);
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_ready8();
    @(negedge clk);
    chk_period = 1'b0;
    chk("t6_b2b_drained", q8.size(), 0);

    // Reset four edges after accept aborts the operation
    start_op(8'h33, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t7_reset_diff_bout", {bout, diff}, 9'h000);
    chk("t7_reset_busy_done", {busy, done}, 2'b00);
    repeat (15) @(negedge clk);
    chk("t7_no_done_after_abort", {busy, done, bout, diff}, 11'h000);

    // Exhaustive WIDTH=4
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          n = 0;
          while (busy4 === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
          end
          if (n >= 50) chk("wait_ready4_timeout", 1, 0);
          a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic);
          q4.push_back(5'({1'b0, a4} - {1'b0, b4} - {4'b0000, bin4}));
          start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        end
      end
    end
    n = 0;
    while (busy4 === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("t8_exhaustive_drained", q4.size(), 0);
    chk("final_dut8_queue_empty", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
